// File: rtl/nes_prog_loader.sv
// nes_prog_loader: streams a program image into the NES over its command port.
// Each load holds the CPU in reset, pauses it, writes every streamed byte with
// WRITE_MEM at consecutive addresses, and (optionally) restarts the CPU.
// Command words on writedata are {nes_op, data}; chipselect always mirrors write.
module nes_prog_loader #(
  parameter int RESET_CYCLES = 4,
  parameter int GAP_CYCLES   = 1,
  parameter bit AUTO_START   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] load_addr,
  input  logic [15:0] load_len,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        chipselect,
  output logic        write,
  output logic [15:0] address,
  output logic [15:0] writedata,
  output logic        busy,
  output logic        done
);

  localparam logic [7:0] OP_RESET_CPU = 8'd0;
  localparam logic [7:0] OP_START_CPU = 8'd1;
  localparam logic [7:0] OP_PAUSE_CPU = 8'd2;
  localparam logic [7:0] OP_WRITE_MEM = 8'd3;

  // Down-counters are preloaded with "cycles - 1" so a zero count marks the last cycle.
  localparam logic [7:0] RST_LAST = 8'(RESET_CYCLES - 1);
  localparam logic [7:0] GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
  localparam bit         HAS_GAP  = (GAP_CYCLES > 0);

  typedef enum logic [2:0] {
    IDLE,
    RST,
    PAUSE,
    WAIT,
    GAP,
    FIN,
    DONE
  } state_t;

  state_t      state;
  logic [15:0] cur_addr;
  logic [15:0] remaining;
  logic [7:0]  cycle_cnt;
  logic [15:0] next_addr;
  logic [15:0] next_remaining;

  assign next_addr      = cur_addr + 16'd1;
  assign next_remaining = remaining - 16'd1;

  // The bus select is the registered write strobe itself, so the two can never disagree.
  assign chipselect = write;

  // Sequencer: every output is set on the transition into the cycle that uses it.
  // In WAIT, a high in_ready means "offering"; once a byte is taken in_ready drops
  // and the following WAIT cycle is the WRITE_MEM bus cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      write     <= 1'b0;
      address   <= 16'd0;
      writedata <= 16'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cur_addr  <= 16'd0;
      remaining <= 16'd0;
      cycle_cnt <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cur_addr  <= load_addr;
            remaining <= load_len;
            cycle_cnt <= RST_LAST;
            write     <= 1'b1;
            address   <= load_addr;
            writedata <= {OP_RESET_CPU, 8'd0};
            busy      <= 1'b1;
            state     <= RST;
          end
        end

        RST: begin
          if (cycle_cnt == 8'd0) begin
            writedata <= {OP_PAUSE_CPU, 8'd0};
            state     <= PAUSE;
          end else begin
            cycle_cnt <= cycle_cnt - 8'd1;
          end
        end

        PAUSE: begin
          if (remaining == 16'd0) begin
            write <= AUTO_START;
            if (AUTO_START) begin
              writedata <= {OP_START_CPU, 8'd0};
            end
            state <= FIN;
          end else begin
            write    <= 1'b0;
            in_ready <= 1'b1;
            state    <= WAIT;
          end
        end

        WAIT: begin
          if (in_ready) begin
            if (in_valid) begin
              in_ready  <= 1'b0;
              write     <= 1'b1;
              address   <= cur_addr;
              writedata <= {OP_WRITE_MEM, in_data};
            end
          end else begin
            write     <= 1'b0;
            cur_addr  <= next_addr;
            remaining <= next_remaining;
            if (HAS_GAP) begin
              cycle_cnt <= GAP_LAST;
              state     <= GAP;
            end else if (next_remaining != 16'd0) begin
              in_ready <= 1'b1;
            end else begin
              write <= AUTO_START;
              if (AUTO_START) begin
                writedata <= {OP_START_CPU, 8'd0};
              end
              state <= FIN;
            end
          end
        end

        GAP: begin
          if (cycle_cnt == 8'd0) begin
            if (remaining != 16'd0) begin
              in_ready <= 1'b1;
              state    <= WAIT;
            end else begin
              write <= AUTO_START;
              if (AUTO_START) begin
                writedata <= {OP_START_CPU, 8'd0};
              end
              state <= FIN;
            end
          end else begin
            cycle_cnt <= cycle_cnt - 8'd1;
          end
        end

        FIN: begin
          write <= 1'b0;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= DONE;
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nes_prog_loader.sv
// tb_nes_prog_loader: scoreboard bench for nes_prog_loader. Two instances run:
// dut A (RESET_CYCLES=4, GAP=1, AUTO_START=1) and dut B (RESET_CYCLES=2, GAP=2,
// AUTO_START=0). Stimulus queues the expected bus events; a negedge monitor pops
// and compares them, including the cycle spacing between consecutive events.
module tb_nes_prog_loader;

  logic clk = 1'b0;
  logic reset;

  logic        start, in_valid, in_ready, chipselect, write, busy, done;
  logic [15:0] load_addr, load_len, address, writedata;
  logic [7:0]  in_data;

  logic        b_start, b_in_valid, b_in_ready, b_chipselect, b_write, b_busy, b_done;
  logic [15:0] b_load_addr, b_load_len, b_address, b_writedata;
  logic [7:0]  b_in_data;

  typedef struct {
    bit          is_done;
    bit          chk_addr;
    logic [15:0] addr;
    logic [15:0] data;
    int          gap;
  } ev_t;

  ev_t        qa[$];
  ev_t        qb[$];
  logic [7:0] bytes_q[$];
  int         compared   = 0;
  int         mismatched = 0;
  int         cyc        = 0;
  int         last_cyc[2];
  int         cs_bad     = 0;
  bit         ready_seen = 1'b0;

  nes_prog_loader #(.RESET_CYCLES(4), .GAP_CYCLES(1), .AUTO_START(1'b1)) dut_a (
    .clk(clk), .reset(reset), .start(start), .load_addr(load_addr), .load_len(load_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .chipselect(chipselect),
    .write(write), .address(address), .writedata(writedata), .busy(busy), .done(done)
  );

  nes_prog_loader #(.RESET_CYCLES(2), .GAP_CYCLES(2), .AUTO_START(1'b0)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .load_addr(b_load_addr), .load_len(b_load_len),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready), .chipselect(b_chipselect),
    .write(b_write), .address(b_address), .writedata(b_writedata), .busy(b_busy), .done(b_done)
  );

  // 100 MHz clock and a free-running cycle stamp for spacing checks.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name, input logic [63:0] actual);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: got %0h, expected no such event", name, actual);
  endtask

  task automatic pushEv(input int k, input bit is_done, input bit chk_addr,
                        input logic [15:0] addr, input logic [15:0] data, input int gap);
    ev_t e;
    e.is_done  = is_done;
    e.chk_addr = chk_addr;
    e.addr     = addr;
    e.data     = data;
    e.gap      = gap;
    if (k == 0) qa.push_back(e);
    else        qb.push_back(e);
  endtask

  // RESET_CPU repeated nrst times at addr on consecutive cycles, then PAUSE_CPU.
  task automatic pushPreamble(input int k, input int nrst, input logic [15:0] addr);
    for (int i = 0; i < nrst; i++) pushEv(k, 1'b0, 1'b1, addr, 16'h0000, (i == 0) ? 0 : 1);
    pushEv(k, 1'b0, 1'b0, 16'h0000, 16'h0200, 1);
  endtask

  task automatic monitorStep(input int k);
    logic        wr, dn, cs;
    logic [15:0] ad, wd;
    ev_t         e;
    int          pending;
    wr      = (k == 0) ? write      : b_write;
    dn      = (k == 0) ? done       : b_done;
    cs      = (k == 0) ? chipselect : b_chipselect;
    ad      = (k == 0) ? address    : b_address;
    wd      = (k == 0) ? writedata  : b_writedata;
    pending = (k == 0) ? qa.size()  : qb.size();
    if (cs !== wr) cs_bad++;
    if (k == 0 && in_ready === 1'b1) ready_seen = 1'b1;
    if (wr === 1'b1 || dn === 1'b1) begin
      if (pending == 0) begin
        reportFail($sformatf("dut%0d_unexpected_event", k), {wr, dn, ad, wd});
      end else begin
        if (k == 0) e = qa.pop_front();
        else        e = qb.pop_front();
        if (e.is_done) begin
          checkOutput($sformatf("dut%0d_done_event", k), {wr, dn}, 2'b01);
        end else begin
          checkOutput($sformatf("dut%0d_write_word", k), {wr, dn, wd}, {2'b10, e.data});
          if (e.chk_addr) checkOutput($sformatf("dut%0d_write_addr", k), ad, e.addr);
        end
        if (e.gap != 0) checkOutput($sformatf("dut%0d_event_spacing", k), cyc - last_cyc[k], e.gap);
      end
      last_cyc[k] = cyc;
    end
  endtask

  // Monitor: compares every bus write and done pulse against the scoreboard queues.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      monitorStep(0);
      monitorStep(1);
    end
  end

  // One-cycle start pulse on dut A; inputs are scrambled afterwards to prove latching.
  task automatic applyStimulus(input logic [15:0] addr, input logic [15:0] len);
    @(negedge clk);
    start     = 1'b1;
    load_addr = addr;
    load_len  = len;
    @(negedge clk);
    start     = 1'b0;
    load_addr = 16'hDEAD;
    load_len  = 16'h0009;
  endtask

  task automatic waitReady(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (in_ready === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) reportFail("in_ready_timeout", {63'd0, in_ready});
  endtask

  task automatic waitDone(input int k);
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (((k == 0) ? done : b_done) === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) reportFail($sformatf("dut%0d_done_timeout", k), 64'd0);
    else checkOutput($sformatf("dut%0d_busy_low_at_done", k), (k == 0) ? busy : b_busy, 1'b0);
  endtask

  task automatic finishDone(input int k);
    @(negedge clk);
    start   = 1'b0;
    b_start = 1'b0;
    if (k == 0) checkOutput("dut0_after_done", {done, busy}, 2'b00);
    else        checkOutput("dut1_after_done", {b_done, b_busy}, 2'b00);
  endtask

  // Streams bytes_q into dut A; optional stall with in_valid low before byte stall_idx.
  task automatic sendBytes(input int stall_idx, input int stall_len);
    bit ok;
    for (int i = 0; i < bytes_q.size(); i++) begin
      if (i == stall_idx) begin
        in_valid = 1'b0;
        waitReady(ok);
        for (int s = 0; s < stall_len; s++) begin
          checkOutput("stall_ready_held", in_ready, 1'b1);
          checkOutput("stall_no_write", write, 1'b0);
          @(negedge clk);
        end
      end
      in_valid = 1'b1;
      in_data  = bytes_q[i];
      waitReady(ok);
      @(negedge clk);
      checkOutput("write_after_handshake", {write, writedata}, {1'b1, 8'h03, bytes_q[i]});
    end
    in_valid = 1'b0;
  endtask

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "[TB] timeout");
  end

  // Directed test sequence.
  initial begin
    bit ok;
    last_cyc[0] = 0;
    last_cyc[1] = 0;
    reset = 1'b1;
    start = 1'b0; load_addr = 16'd0; load_len = 16'd0; in_valid = 1'b0; in_data = 8'd0;
    b_start = 1'b0; b_load_addr = 16'd0; b_load_len = 16'd0; b_in_valid = 1'b0; b_in_data = 8'd0;
    #2;
    checkOutput("dut0_reset_state", {in_ready, chipselect, write, address, writedata, busy, done}, 0);
    checkOutput("dut1_reset_state", {b_in_ready, b_chipselect, b_write, b_address, b_writedata, b_busy, b_done}, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    $display("[TB] basic load of three bytes at 8000");
    pushPreamble(0, 4, 16'h8000);
    pushEv(0, 1'b0, 1'b1, 16'h8000, 16'h03AA, 2);
    pushEv(0, 1'b0, 1'b1, 16'h8001, 16'h03BB, 3);
    pushEv(0, 1'b0, 1'b1, 16'h8002, 16'h03CC, 3);
    pushEv(0, 1'b0, 1'b0, 16'h0000, 16'h0100, 2);
    pushEv(0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1);
    applyStimulus(16'h8000, 16'd3);
    checkOutput("busy_after_start", busy, 1'b1);
    bytes_q = {8'hAA, 8'hBB, 8'hCC};
    sendBytes(-1, 0);
    waitDone(0);
    finishDone(0);

    $display("[TB] zero-length load");
    ready_seen = 1'b0;
    pushPreamble(0, 4, 16'h1234);
    pushEv(0, 1'b0, 1'b0, 16'h0000, 16'h0100, 1);
    pushEv(0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1);
    applyStimulus(16'h1234, 16'd0);
    waitDone(0);
    finishDone(0);
    checkOutput("ready_never_len0", ready_seen, 1'b0);

    $display("[TB] address wrap");
    pushPreamble(0, 4, 16'hFFFF);
    pushEv(0, 1'b0, 1'b1, 16'hFFFF, 16'h0311, 2);
    pushEv(0, 1'b0, 1'b1, 16'h0000, 16'h0322, 3);
    pushEv(0, 1'b0, 1'b0, 16'h0000, 16'h0100, 2);
    pushEv(0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1);
    applyStimulus(16'hFFFF, 16'd2);
    bytes_q = {8'h11, 8'h22};
    sendBytes(-1, 0);
    waitDone(0);
    finishDone(0);

    $display("[TB] stream stall before second byte");
    pushPreamble(0, 4, 16'h0100);
    pushEv(0, 1'b0, 1'b1, 16'h0100, 16'h035A, 2);
    pushEv(0, 1'b0, 1'b1, 16'h0101, 16'h03A5, 0);
    pushEv(0, 1'b0, 1'b0, 16'h0000, 16'h0100, 2);
    pushEv(0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1);
    applyStimulus(16'h0100, 16'd2);
    bytes_q = {8'h5A, 8'hA5};
    sendBytes(1, 10);
    waitDone(0);
    finishDone(0);

    $display("[TB] start ignored mid-load and during done");
    pushPreamble(0, 4, 16'h2000);
    pushEv(0, 1'b0, 1'b1, 16'h2000, 16'h0301, 2);
    pushEv(0, 1'b0, 1'b1, 16'h2001, 16'h0302, 0);
    pushEv(0, 1'b0, 1'b0, 16'h0000, 16'h0100, 2);
    pushEv(0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1);
    applyStimulus(16'h2000, 16'd2);
    repeat (2) @(negedge clk);
    applyStimulus(16'h3000, 16'd5);
    bytes_q = {8'h01};
    sendBytes(-1, 0);
    applyStimulus(16'h3000, 16'd5);
    bytes_q = {8'h02};
    sendBytes(-1, 0);
    waitDone(0);
    start     = 1'b1;
    load_addr = 16'h7000;
    load_len  = 16'd1;
    finishDone(0);
    repeat (10) @(negedge clk);
    checkOutput("dut0_queue_drained_after_ignored_start", qa.size(), 0);
    checkOutput("dut0_idle_after_ignored_start", busy, 1'b0);

    $display("[TB] AUTO_START=0 instance");
    pushPreamble(1, 2, 16'h4000);
    pushEv(1, 1'b0, 1'b1, 16'h4000, 16'h0377, 2);
    pushEv(1, 1'b1, 1'b0, 16'h0000, 16'h0000, 4);
    @(negedge clk);
    b_start = 1'b1; b_load_addr = 16'h4000; b_load_len = 16'd1; b_in_valid = 1'b1; b_in_data = 8'h77;
    @(negedge clk);
    b_start = 1'b0; b_load_addr = 16'hBEEF; b_load_len = 16'd3;
    checkOutput("dut1_busy_after_start", b_busy, 1'b1);
    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    waitDone(1);
    b_in_valid = 1'b0;
    b_start    = 1'b1;
    finishDone(1);
    repeat (8) @(negedge clk);
    checkOutput("dut1_queue_drained", qb.size(), 0);

    $display("[TB] async reset after second handshake");
    pushPreamble(0, 4, 16'h5000);
    pushEv(0, 1'b0, 1'b1, 16'h5000, 16'h0331, 2);
    applyStimulus(16'h5000, 16'd3);
    in_valid = 1'b1;
    in_data  = 8'h31;
    waitReady(ok);
    @(negedge clk);
    checkOutput("abort_first_write", {write, writedata}, {1'b1, 16'h0331});
    in_data = 8'h32;
    waitReady(ok);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    checkOutput("abort_outputs_low", {write, chipselect, busy, in_ready}, 4'b0000);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("abort_queue_drained", qa.size(), 0);
    checkOutput("abort_stays_idle", {busy, in_ready}, 2'b00);

    $display("[TB] full sequence after abort");
    pushPreamble(0, 4, 16'h6000);
    pushEv(0, 1'b0, 1'b1, 16'h6000, 16'h0344, 2);
    pushEv(0, 1'b0, 1'b0, 16'h0000, 16'h0100, 2);
    pushEv(0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1);
    applyStimulus(16'h6000, 16'd1);
    bytes_q = {8'h44};
    sendBytes(-1, 0);
    waitDone(0);
    finishDone(0);
    repeat (4) @(negedge clk);
    checkOutput("final_queue_a_drained", qa.size(), 0);
    checkOutput("final_queue_b_drained", qb.size(), 0);
    checkOutput("chipselect_equals_write", cs_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/nes_prog_loader.md
Name: nes_prog_loader

Overview:
- Host-side initiator for the NES command port. It drives the chipselect/write/address/writedata bus that the NES top decodes as {nes_op, data}.
- It takes a ROM/program byte stream on a valid/ready input and runs a fixed sequence: hold CPU in reset, pause, write each byte with WRITE_MEM at consecutive addresses, then optionally START_CPU.
- It replaces ad-hoc software poking and sits between a stream source (DMA/FIFO) and the NES command slave.

Parameters:
- RESET_CYCLES, 4: consecutive cycles the RESET_CPU command is held. Range 1..255.
- GAP_CYCLES, 1: idle bus cycles inserted after each WRITE_MEM. 0 allowed.
- AUTO_START, 1: 1 means issue START_CPU after the last byte; 0 means leave the CPU paused.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a load; sampled only in IDLE
- load_addr  in  16  first target address; latched on an accepted start
- load_len  in  16  byte count; latched on an accepted start; 0 is legal
- in_valid  in  1  stream byte valid
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts in_data this cycle
- chipselect  out  1  command bus select
- write  out  1  command bus write strobe
- address  out  16  command bus address
- writedata  out  16  [15:8] = nes_op, [7:0] = data
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at sequence end

Behaviour:
- Opcodes: RESET_CPU=8'd0, START_CPU=8'd1, PAUSE_CPU=8'd2, WRITE_MEM=8'd3.
- All outputs are registered. Reset (async assert) forces:
  - state=IDLE
  - in_ready=0, chipselect=0, write=0, address=0, writedata=0
  - busy=0, done=0
  - internal address and count registers to 0
- chipselect equals write at all times. Each command is one cycle, except RESET_CPU.
- On cycles with no command, write=0 and address/writedata hold their last values.
- States: IDLE, RST, PAUSE, WAIT, GAP, FIN, DONE.
- IDLE: busy=0. start=1 in cycle N latches load_addr→cur_addr and load_len→remaining, then moves to RST; busy=1 from N+1.
- start while busy=1 is ignored. It is not queued.
- RST: write=1, writedata={8'd0,8'd0}, address=cur_addr. Held exactly RESET_CYCLES cycles, then PAUSE.
- PAUSE: one cycle of write=1, writedata={8'd2,8'd0}.
  - remaining==0 → FIN.
  - otherwise → WAIT.
- WAIT: in_ready=1 and write=0.
  - The handshake is in_valid&in_ready in cycle M.
  - In cycle M+1: write=1, address=cur_addr, writedata={8'd3,in_data@M}, in_ready=0.
  - After that write cycle: cur_addr+1 (16-bit wrap, 16'hFFFF→16'h0000), remaining-1.
  - If GAP_CYCLES>0, go to GAP for exactly GAP_CYCLES cycles (write=0, in_ready=0).
  - Then WAIT if remaining≠0, else FIN.
  - Back-to-back accepted bytes are therefore spaced 2+GAP_CYCLES cycles apart.
- in_valid low in WAIT: stay in WAIT indefinitely with in_ready=1. There is no timeout.
- FIN:
  - AUTO_START=1 → one cycle write=1, writedata={8'd1,8'd0}, then DONE.
  - AUTO_START=0 → no write, then DONE directly.
- DONE: done=1 for one cycle, busy=0 in that same cycle, next state IDLE.
- A start asserted during DONE is ignored.
- in_ready is never 1 outside WAIT. Bytes offered at other times are not consumed.
- Async reset mid-sequence: abort immediately, with no partial command completed. The downstream sees write drop to 0 with no trailing START_CPU.

Test Plan:
- Reset, then start with load_addr=16'h8000, load_len=3, RESET_CYCLES=4, GAP=1, AUTO_START=1, stream AA,BB,CC always valid → required response:
  - 4 writes of 16'h0000
  - 1 write of 16'h0200
  - writes 16'h03AA@8000, 16'h03BB@8001, 16'h03CC@8002, spaced 3 cycles apart
  - 1 write of 16'h0100
  - done pulse one cycle later; busy low thereafter.
- load_len=0, AUTO_START=1 → required response: RESET×4, PAUSE, START, done. in_ready never asserted.
- Wrap: load_addr=16'hFFFF, len=2, data 11,22 → required response: writes 16'h0311@FFFF, then 16'h0322@0000.
- Stream stall: in_valid low for 10 cycles before the 2nd byte → required response: in_ready stays 1 and no bus write during the stall. The 2nd write occurs exactly 1 cycle after the handshake.
- start pulsed again mid-load, and during DONE → required response: ignored; byte count and addresses unchanged. AUTO_START=0 variant ends with no 16'h01xx write.
- Async reset asserted in the cycle after the 2nd handshake → required response: write=0, busy=0, in_ready=0 immediately; no further bus writes. A new start then runs the full sequence from RST.
